// File: rtl/channel_merge.sv
// channel_merge: routes one of two synchronized line pairs (A = frequency, B = current) onto int_a_o/int_b_o.
// Latency: 3 clk edges from input change to output in a RUN state; a changeover idles the outputs for DEAD cycles.
// Backpressure: none; sel_req_i is sampled only in RUN states and a started gap always runs to completion.
module channel_merge #(
    parameter int unsigned DEAD     = 4,
    parameter int unsigned CONF_LEN = 8
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic a_1_i,
    input  logic a_2_i,
    input  logic b_1_i,
    input  logic b_2_i,
    input  logic sel_req_i,
    input  logic conf_clr_i,
    output logic int_a_o,
    output logic int_b_o,
    output logic sel_act_o,
    output logic busy_o,
    output logic conflict_o
);

    localparam logic [7:0] GAP_LOAD = 8'(DEAD - 1);
    localparam logic [7:0] CONF_MAX = 8'(CONF_LEN);
    localparam logic [7:0] CONF_PRE = 8'(CONF_LEN - 1);

    typedef enum logic [1:0] {
        RUN_A  = 2'd0,
        GAP_AB = 2'd1,
        RUN_B  = 2'd2,
        GAP_BA = 2'd3
    } state_t;

    // Bit order of the line vectors: [0] A_1, [1] A_2, [2] B_1, [3] B_2.
    logic [3:0] sync1_q;
    logic [3:0] sync2_q;

    state_t     state_q;
    logic [7:0] gap_cnt_q;
    logic       int_a_q;
    logic       int_b_q;
    logic       sel_act_q;
    logic       busy_q;

    logic       inactive_hit;
    logic [7:0] conf_cnt_q;
    logic [7:0] conf_cnt_d;
    logic       conf_set;
    logic       conflict_q;

    // Two-flop synchronizer for all four asynchronous lines.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync1_q <= 4'd0;
            sync2_q <= 4'd0;
        end else begin
            sync1_q <= {b_2_i, b_1_i, a_2_i, a_1_i};
            sync2_q <= sync1_q;
        end
    end

    // Activity on the pair that is not routed; never counted during a gap.
    always_comb begin
        inactive_hit = 1'b0;
        case (state_q)
            RUN_A:   inactive_hit = sync2_q[2] | sync2_q[3];
            RUN_B:   inactive_hit = sync2_q[0] | sync2_q[1];
            default: inactive_hit = 1'b0;
        endcase
    end

    // Saturating run-length counter of inactive-pair activity; set fires only on the step into CONF_LEN.
    always_comb begin
        conf_cnt_d = 8'd0;
        conf_set   = 1'b0;
        if (inactive_hit) begin
            if (conf_cnt_q != CONF_MAX) begin
                conf_cnt_d = conf_cnt_q + 8'd1;
            end else begin
                conf_cnt_d = conf_cnt_q;
            end
            conf_set = (conf_cnt_q == CONF_PRE);
        end
    end

    // Conflict counter and sticky flag; a set in the same cycle as a clear wins.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            conf_cnt_q <= 8'd0;
            conflict_q <= 1'b0;
        end else begin
            conf_cnt_q <= conf_cnt_d;
            if (conf_set) begin
                conflict_q <= 1'b1;
            end else if (conf_clr_i) begin
                conflict_q <= 1'b0;
            end
        end
    end

    // Routing FSM; outputs are registered alongside the state so they always match it.
    // The gap counter is loaded on the entry edge so that exactly DEAD busy cycles elapse.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= RUN_A;
            gap_cnt_q <= 8'd0;
            int_a_q   <= 1'b0;
            int_b_q   <= 1'b0;
            sel_act_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                RUN_A: begin
                    if (sel_req_i) begin
                        state_q   <= GAP_AB;
                        gap_cnt_q <= GAP_LOAD;
                        int_a_q   <= 1'b0;
                        int_b_q   <= 1'b0;
                        sel_act_q <= 1'b0;
                        busy_q    <= 1'b1;
                    end else begin
                        int_a_q   <= sync2_q[0];
                        int_b_q   <= sync2_q[1];
                        sel_act_q <= 1'b0;
                        busy_q    <= 1'b0;
                    end
                end
                GAP_AB: begin
                    if (gap_cnt_q == 8'd0) begin
                        state_q   <= RUN_B;
                        int_a_q   <= sync2_q[2];
                        int_b_q   <= sync2_q[3];
                        sel_act_q <= 1'b1;
                        busy_q    <= 1'b0;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 8'd1;
                    end
                end
                RUN_B: begin
                    if (!sel_req_i) begin
                        state_q   <= GAP_BA;
                        gap_cnt_q <= GAP_LOAD;
                        int_a_q   <= 1'b0;
                        int_b_q   <= 1'b0;
                        sel_act_q <= 1'b0;
                        busy_q    <= 1'b1;
                    end else begin
                        int_a_q   <= sync2_q[2];
                        int_b_q   <= sync2_q[3];
                        sel_act_q <= 1'b1;
                        busy_q    <= 1'b0;
                    end
                end
                GAP_BA: begin
                    if (gap_cnt_q == 8'd0) begin
                        state_q   <= RUN_A;
                        int_a_q   <= sync2_q[0];
                        int_b_q   <= sync2_q[1];
                        sel_act_q <= 1'b0;
                        busy_q    <= 1'b0;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_q   <= RUN_A;
                    int_a_q   <= 1'b0;
                    int_b_q   <= 1'b0;
                    sel_act_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign int_a_o    = int_a_q;
    assign int_b_o    = int_b_q;
    assign sel_act_o  = sel_act_q;
    assign busy_o     = busy_q;
    assign conflict_o = conflict_q;

endmodule

// File: doc/channel_merge.md
CHANNEL_MERGE -- requirements
Module: channel_merge

Interface
REQ-001 Parameter: DEAD, 4, dead-time length in clk cycles during a channel changeover (legal range 1..255).
REQ-002 Parameter: CONF_LEN, 8, consecutive cycles the inactive pair must be high before conflict is flagged (legal range 1..255).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 A_1  input  1  frequency-channel line 1, asynchronous to clk.
REQ-006 A_2  input  1  frequency-channel line 2, asynchronous to clk.
REQ-007 B_1  input  1  current-channel line 1, asynchronous to clk.
REQ-008 B_2  input  1  current-channel line 2, asynchronous to clk.
REQ-009 sel_req  input  1  synchronous to clk; requested source, 0 = A pair (frequency), 1 = B pair (current).
REQ-010 conf_clr  input  1  synchronous to clk; clears the sticky conflict flag.
REQ-011 int_A  output  1  registered merged line 1 (A_1 or B_1).
REQ-012 int_B  output  1  registered merged line 2 (A_2 or B_2).
REQ-013 sel_act  output  1  registered; 1 only while the B pair is routed.
REQ-014 busy  output  1  registered; 1 during a dead-time gap.
REQ-015 conflict  output  1  registered, sticky; inactive pair was driven high.

Function
REQ-016 A_1, A_2, B_1 and B_2 SHALL each pass through a two-flop synchronizer before any use.
REQ-017 The FSM SHALL have exactly four states: RUN_A, GAP_AB, RUN_B and GAP_BA.
REQ-018 In RUN_A: int_A = synced A_1, int_B = synced A_2, sel_act = 0, busy = 0.
REQ-019 In RUN_B: int_A = synced B_1, int_B = synced B_2, sel_act = 1, busy = 0.
REQ-020 In GAP_AB and GAP_BA: int_A = int_B = 0, sel_act = 0, busy = 1.
REQ-021 Data-path latency in a RUN state SHALL be exactly 3 clk edges from input change to output change (2 synchronizer stages plus the output register).
REQ-022 sel_req is sampled only in the RUN states.
REQ-023 RUN_A with sel_req = 1 SHALL go to GAP_AB on the next edge.
REQ-024 RUN_B with sel_req = 0 SHALL go to GAP_BA on the next edge.
REQ-025 The first edge after entering a GAP state SHALL load an 8-bit gap counter with DEAD-1; each further edge SHALL decrement it.
REQ-026 A GAP state SHALL exit to its target RUN state (GAP_AB to RUN_B, GAP_BA to RUN_A) on the edge where the counter is 0, giving exactly DEAD cycles with busy = 1.
REQ-027 sel_req is ignored during a gap; the gap always completes.
REQ-028 If sel_req disagrees with the new RUN state, the reverse gap SHALL start on the following edge; there is no direct GAP-to-GAP transition.
REQ-029 In RUN_A, an 8-bit conflict counter SHALL increment each cycle that (synced B_1 | synced B_2) = 1 and clear to 0 otherwise.
REQ-030 In RUN_B, the conflict counter SHALL behave the same way with (synced A_1 | synced A_2).
REQ-031 The conflict counter SHALL saturate at CONF_LEN and SHALL be cleared while in a GAP state.
REQ-032 conflict SHALL set on the edge where the conflict counter reaches CONF_LEN and SHALL stay set until conf_clr = 1.
REQ-033 If conf_clr = 1 and the set condition occur in the same cycle, the set condition SHALL win.
REQ-034 conflict SHALL NOT change int_A, int_B or any routing.

Reset
REQ-035 reset = 1 SHALL immediately, without waiting for a clk edge, force: state RUN_A, both counters 0, all synchronizer flops 0, int_A = int_B = sel_act = busy = conflict = 0.
REQ-036 reset asserted in the middle of a gap SHALL abandon the gap; after release the block is in RUN_A regardless of sel_req.
REQ-037 After reset release, a sel_req = 1 that is already held SHALL start GAP_AB on the first edge.

Verification
REQ-038 Pass-through: after reset release with sel_req = 0, drive A_1 = 1 -> int_A = 1 exactly 3 edges later; B_1 toggling has no effect on int_A.
REQ-039 Changeover: DEAD = 4, sel_req goes 0 to 1 -> busy = 1 and outputs 0 for exactly 4 cycles, then sel_act = 1 and int_B follows B_2.
REQ-040 Mid-gap request: DEAD = 4, sel_req goes 1 then back to 0 during GAP_AB -> 4 gap cycles, 1 RUN_B cycle, then 4 GAP_BA cycles, ending in RUN_A.
REQ-041 Conflict: CONF_LEN = 8, in RUN_A hold B_2 = 1 for 7 cycles then 0 -> conflict stays 0; holding it 8 cycles -> conflict = 1 and stays 1 until conf_clr = 1.
REQ-042 Reset mid-gap: assert reset in gap cycle 2 -> all outputs 0 immediately, without a clk edge; after release the block is in RUN_A.
REQ-043 Clear versus set: conf_clr = 1 in the same cycle the conflict counter reaches CONF_LEN -> conflict = 1.
